// File: rtl/wash_run_pkg.sv
// rtl/wash_run_pkg.sv - wash_run state encoding, mode table and phase light codes
package wash_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_WASH   = 3'd2,
    S_RINSE  = 3'd3,
    S_SPIN   = 3'd4,
    S_PAUSE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [2:0] PH_NONE  = 3'b000;
  localparam logic [2:0] PH_WASH  = 3'b001;
  localparam logic [2:0] PH_RINSE = 3'b010;
  localparam logic [2:0] PH_SPIN  = 3'b100;

  // Indexed by mode: 0 quick, 1 standard, 2 heavy, 3 spin-only
  localparam logic [6:0]         WASH_S    [4] = '{7'd30, 7'd60, 7'd90, 7'd0};
  localparam logic [6:0]         RINSE_S   [4] = '{7'd20, 7'd40, 7'd60, 7'd0};
  localparam logic [6:0]         SPIN_S    [4] = '{7'd10, 7'd20, 7'd30, 7'd30};
  localparam logic signed [11:0] PRICE     [4] = '{12'sd3, 12'sd5, 12'sd8, 12'sd2};
  localparam logic [11:0]        TOTAL_BCD [4] = '{12'h060, 12'h120, 12'h180, 12'h030};

  // CHARGE acts as "before wash", so this also yields the first running phase
  function automatic state_t next_phase(input state_t s, input logic [1:0] m);
    case (s)
      S_CHARGE: next_phase = (WASH_S[m] != 7'd0) ? S_WASH :
                             ((RINSE_S[m] != 7'd0) ? S_RINSE : S_SPIN);
      S_WASH:   next_phase = (RINSE_S[m] != 7'd0) ? S_RINSE : S_SPIN;
      S_RINSE:  next_phase = S_SPIN;
      default:  next_phase = S_DONE;
    endcase
  endfunction

  function automatic logic [6:0] phase_dur(input state_t s, input logic [1:0] m);
    case (s)
      S_WASH:  phase_dur = WASH_S[m];
      S_RINSE: phase_dur = RINSE_S[m];
      S_SPIN:  phase_dur = SPIN_S[m];
      default: phase_dur = 7'd0;
    endcase
  endfunction

  function automatic logic [2:0] ph_code(input state_t s);
    case (s)
      S_WASH:  ph_code = PH_WASH;
      S_RINSE: ph_code = PH_RINSE;
      S_SPIN:  ph_code = PH_SPIN;
      default: ph_code = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wash_run_bcd_down3.sv
// rtl/wash_run_bcd_down3.sv - 3-digit BCD down-counter with load, decrement and zero flag
module bcd_down3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        dec,
  output logic [11:0] q,
  output logic        zero
);

  assign zero = (q == 12'h000);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 12'h000;
    end else if (load) begin
      q <= load_val;
    end else if (dec && !zero) begin
      if (q[3:0] != 4'd0) begin
        q[3:0] <= q[3:0] - 4'd1;
      end else begin
        q[3:0] <= 4'd9;
        if (q[7:4] != 4'd0) begin
          q[7:4] <= q[7:4] - 4'd1;
        end else begin
          q[7:4]  <= 4'd9;
          q[11:8] <= q[11:8] - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/wash_run.sv
// rtl/wash_run.sv - wash cycle execution: charge, wash/rinse/spin on a 1 s tick, BCD countdown
// Optional run/pause toggle built only when WASH_PAUSE_EN is defined.
module wash_run
  import wash_run_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic signed [11:0] bal_in,
  input  logic               pause,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         phase,
  output logic [11:0]        rem_bcd,
  output logic signed [11:0] bal_out
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t             state, state_nx, adv, first;
  logic [TW-1:0]      tick_cnt;
  logic [6:0]         ph_cnt;
  logic [1:0]         mode_q;
  logic signed [11:0] bal_q;
  logic               run, tick, last, charge_ok, pause_go, rem_zero;

`ifdef WASH_PAUSE_EN
  state_t saved_q;
  assign pause_go = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_go     = 1'b0;
`endif

  assign run       = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN);
  assign tick      = run && (tick_cnt == TW'(TICK_DIV - 1));
  assign last      = tick && (ph_cnt == 7'd1);
  assign charge_ok = (state == S_CHARGE) && (bal_q >= PRICE[mode_q]);
  assign first     = next_phase(S_CHARGE, mode_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

`ifdef WASH_PAUSE_EN
  // Post-tick phase, so a pause on the zeroing tick resumes into the next phase
  always_ff @(posedge clk) begin
    if (rst)                              saved_q <= S_WASH;
    else if (run && state_nx == S_PAUSE)  saved_q <= adv;
  end
`endif

  always_comb begin
    adv      = state;
    state_nx = state;
    if (last) adv = next_phase(state, mode_q);
    case (state)
      S_IDLE:   if (start) state_nx = S_CHARGE;
      S_CHARGE: state_nx = charge_ok ? first : S_IDLE;
      S_WASH, S_RINSE, S_SPIN: begin
        state_nx = adv;
        if (pause_go && adv != S_DONE) state_nx = S_PAUSE;
      end
`ifdef WASH_PAUSE_EN
      S_PAUSE:  if (pause_go) state_nx = saved_q;
`endif
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE) && (state != S_DONE);
    done  = (state == S_DONE);
    phase = ph_code(state);
`ifdef WASH_PAUSE_EN
    if (state == S_PAUSE) phase = ph_code(saved_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      ph_cnt   <= 7'd0;
      mode_q   <= 2'd0;
      bal_q    <= 12'sd0;
      bal_out  <= 12'sd0;
      err      <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_q <= mode;
        bal_q  <= bal_in;
        err    <= 1'b0;
      end
      if (state == S_CHARGE) begin
        tick_cnt <= '0;
        if (charge_ok) begin
          bal_out <= bal_q - PRICE[mode_q];
          ph_cnt  <= phase_dur(first, mode_q);
        end else begin
          err <= 1'b1;
        end
      end
      if (run) begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick) ph_cnt <= last ? phase_dur(adv, mode_q) : ph_cnt - 7'd1;
      end
    end
  end

  bcd_down3 u_rem (
    .clk      (clk),
    .rst      (rst),
    .load     (charge_ok || state == S_DONE),
    .load_val ((state == S_DONE) ? 12'h000 : TOTAL_BCD[mode_q]),
    .dec      (tick && !rem_zero),
    .q        (rem_bcd),
    .zero     (rem_zero)
  );

endmodule

// File: tb/tb_wash_run.sv
// tb/tb_wash_run.sv - self-checking bench for wash_run against a seconds-level model
// Pause scenarios expect freezing only when WASH_PAUSE_EN is defined.
module tb_wash_run;

  localparam int TD = 4;
`ifdef WASH_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int W_T [4] = '{30, 60, 90, 0};
  localparam int R_T [4] = '{20, 40, 60, 0};
  localparam int S_T [4] = '{10, 20, 30, 30};
  localparam int P_T [4] = '{3, 5, 8, 2};

  logic               clk = 1'b0;
  logic               rst, start, pause;
  logic [1:0]         mode;
  logic signed [11:0] bal_in;
  logic               busy, done, err;
  logic [2:0]         phase;
  logic [11:0]        rem_bcd;
  logic signed [11:0] bal_out;

  int checks   = 0;
  int failures = 0;
  int exp_bal  = 0;

  wash_run #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bal_in(bal_in), .pause(pause),
    .busy(busy), .done(done), .err(err), .phase(phase), .rem_bcd(rem_bcd), .bal_out(bal_out)
  );

  always #5 clk = ~clk;

  // {busy, done, err, phase, rem_bcd, bal_out}
  function automatic logic [29:0] obs();
    return {busy, done, err, phase, rem_bcd, bal_out};
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] exp_phase(input int m, input int s);
    if (s < W_T[m])            return 3'b001;
    if (s < W_T[m] + R_T[m])   return 3'b010;
    return 3'b100;
  endfunction

  // Model counts running cycles; elapsed seconds = run cycles / TD
  task automatic run_cycle(input int m, input int b, input int pause_at, input int pause_len,
                           input int abort_rc, input string tag);
    int tot, rc, cyc, pcnt, s;
    bit paused, pz;
    logic [29:0] e;
    tot = W_T[m] + R_T[m] + S_T[m];
    mode = 2'(m); bal_in = 12'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); bal_in = 12'($urandom_range(0, 999));
    e = {3'b100, 3'b000, 12'h000, 12'(exp_bal)};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL %s charge_cycle got=%h exp=%h", tag, obs(), e);
    end
    @(negedge clk);
    if (b < P_T[m]) begin
      e = {3'b001, 3'b000, 12'h000, 12'(exp_bal)};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s low_balance got=%h exp=%h", tag, obs(), e);
      end
      return;
    end
    exp_bal = b - P_T[m];
    rc = 0; cyc = 0; paused = 1'b0; pcnt = 0;
    while (rc < tot * TD) begin
      s = rc / TD;
      e = {3'b100, exp_phase(m, s), to_bcd(tot - s), 12'(exp_bal)};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s run cyc=%0d rc=%0d got=%h exp=%h", tag, cyc, rc, obs(), e);
      end
      if (rc == abort_rc) begin
        start = 1'b0; pause = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_bal = 0;
        checks++;
        if (obs() !== 30'h0) begin
          failures++;
          $display("FAIL %s reset_abort got=%h exp=%h", tag, obs(), 30'h0);
        end
        return;
      end
      start = (cyc == 7);
      pz = (!paused && rc == pause_at) || (paused && pcnt == pause_len);
      pause = pz;
      if (paused) pcnt++;
      if (!paused) rc++;
      if (pz && PEN) begin
        paused = !paused;
        pcnt   = 0;
      end
      mode = 2'($urandom); bal_in = 12'($urandom_range(0, 999));
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        failures++;
        $display("FAIL %s timeout rc=%0d exp_end=%0d", tag, rc, tot * TD);
        break;
      end
    end
    pause = 1'b0; start = 1'b0;
    e = {3'b010, 3'b000, 12'h000, 12'(exp_bal)};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL %s done_pulse got=%h exp=%h", tag, obs(), e);
    end
    @(negedge clk);
    e = {3'b000, 3'b000, 12'h000, 12'(exp_bal)};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL %s back_to_idle got=%h exp=%h", tag, obs(), e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; mode = 2'd0; bal_in = 12'sd0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== 30'h0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", obs(), 30'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== 30'h0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs(), 30'h0);
    end
  endtask

  task automatic test_standard();
    run_cycle(1, 10, -1, 0, -1, "standard");
  endtask

  task automatic test_insufficient();
    logic [29:0] e;
    run_cycle(2, 2, -1, 0, -1, "insufficient");
    e = {3'b001, 3'b000, 12'h000, 12'(exp_bal)};
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL insufficient_stays_idle got=%h exp=%h", obs(), e);
      end
    end
  endtask

  task automatic test_spin_only();
    run_cycle(3, 2, -1, 0, -1, "spin_only");
  endtask

  task automatic test_bcd_borrow();
    run_cycle(0, 999, -1, 0, -1, "bcd_borrow");
  endtask

  task automatic test_pause();
    run_cycle(0, 5, 61, 100, -1, "pause_mid_tick");
    run_cycle(0, 5, 63, 20, -1, "pause_on_tick");
  endtask

  task automatic test_reset_mid_run();
    run_cycle(1, 10, 65 * TD + 2, 0, 65 * TD + 2, "abort_rinse");
    @(negedge clk);
    checks++;
    if (obs() !== 30'h0) begin
      failures++;
      $display("FAIL abort_stays_idle got=%h exp=%h", obs(), 30'h0);
    end
  endtask

  task automatic test_random();
    int m, b, tot;
    for (int i = 0; i < 5; i++) begin
      m   = $urandom_range(0, 3);
      b   = $urandom_range(0, 12);
      tot = W_T[m] + R_T[m] + S_T[m];
      run_cycle(m, b, $urandom_range(0, tot * TD - 2), $urandom_range(0, 10), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_insufficient();
    test_spin_only();
    test_bcd_borrow();
    test_pause();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
